uart_rx_fsm: RTL and testbench

UART_RX_FSM -- requirements
Module: uart_rx_fsm

---
 rtl/uart_rx_fsm.sv | 152 +++++++++++++++
 tb/tb_uart_rx_fsm.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fsm.sv
// Receive-side UART frame sequencer: walks start/data/parity/stop bits using an external
// edge/bit counter, issues sampling/check strobes and reports frame status.
module uart_rx_fsm #(
    parameter int DATA_WIDTH = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic [4:0] prescale,
    input  logic [4:0] bit_cnt,
    input  logic [4:0] edge_cnt,
    input  logic       strt_glitch,
    input  logic       par_err,
    input  logic       stp_err,
    output logic       cnt_enable,
    output logic       dat_samp_en,
    output logic       strt_chk_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
    output logic       deser_en,
    output logic       data_valid,
    output logic       par_error,
    output logic       stop_error,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } state_t;

    localparam logic [4:0] LAST_DATA_BIT = 5'(DATA_WIDTH);

    state_t     state;
    state_t     state_nxt;
    logic       presc_ok;
    logic       bit_end;
    logic       at_chk;
    logic [4:0] last_edge;
    logic [4:0] chk_edge;
    logic       frame_start;
    logic       par_error_nxt;
    logic       stop_error_nxt;
    logic       data_valid_nxt;

    // Mid-bit check point sits two edges past the centre of the bit.
    assign presc_ok  = (prescale == 5'd8) || (prescale == 5'd16);
    assign last_edge = prescale - 5'd1;
    assign chk_edge  = (prescale >> 1) + 5'd2;
    assign bit_end   = (edge_cnt == last_edge);
    assign at_chk    = (edge_cnt == chk_edge);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            data_valid <= 1'b0;
            par_error  <= 1'b0;
            stop_error <= 1'b0;
        end else begin
            state      <= state_nxt;
            data_valid <= data_valid_nxt;
            par_error  <= par_error_nxt;
            stop_error <= stop_error_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_enable     = 1'b0;
        dat_samp_en    = 1'b0;
        strt_chk_en    = 1'b0;
        deser_en       = 1'b0;
        par_chk_en     = 1'b0;
        stp_chk_en     = 1'b0;
        busy           = (state != IDLE);
        frame_start    = 1'b0;
        par_error_nxt  = par_error;
        stop_error_nxt = stop_error;
        data_valid_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (!RX_IN && presc_ok) begin
                    state_nxt = START;
                end
            end
            START: begin
                cnt_enable  = 1'b1;
                dat_samp_en = 1'b1;
                strt_chk_en = at_chk;
                if (bit_end) begin
                    state_nxt = (bit_cnt == 5'd0 && strt_glitch) ? IDLE : DATA;
                end
            end
            DATA: begin
                cnt_enable  = 1'b1;
                dat_samp_en = 1'b1;
                deser_en    = at_chk;
                if (bit_end && bit_cnt == LAST_DATA_BIT) begin
                    state_nxt = PAR_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                cnt_enable  = 1'b1;
                dat_samp_en = 1'b1;
                par_chk_en  = at_chk;
                if (bit_end) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                cnt_enable  = 1'b1;
                dat_samp_en = 1'b1;
                stp_chk_en  = at_chk;
                if (bit_end) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = RX_IN ? IDLE : START;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // An unsupported oversampling ratio abandons whatever frame is in flight.
        if (state != IDLE && !presc_ok) begin
            state_nxt = IDLE;
        end

        frame_start = (state == IDLE || state == DONE) && (state_nxt == START);
        if (frame_start) begin
            par_error_nxt  = 1'b0;
            stop_error_nxt = 1'b0;
        end
        if (state == PARITY && state_nxt == STOP) begin
            par_error_nxt = par_err;
        end
        if (state == STOP && state_nxt == DONE) begin
            stop_error_nxt = stp_err;
        end
        data_valid_nxt = (state == STOP) && (state_nxt == DONE) &&
                         !par_error_nxt && !stop_error_nxt;
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Randomized scoreboard bench for uart_rx_fsm: frames are driven through a modelled
// edge/bit counter, and each frame's outcome is checked against a per-frame model.
module tb_uart_rx_fsm;

    localparam int DW           = 8;
    localparam int ABORT_BIT    = 4;
    localparam int ABORT_EDGE   = 2;
    localparam int FRAME_BUDGET = 400;
    localparam int NUM_RANDOM   = 24;

    typedef struct {
        bit completed;
        bit dv;
        bit pe;
        bit se;
        int strt;
        int deser;
        int parc;
        int stpc;
        int offchk;
        int dvout;
        int cntCyc;
        int sampCyc;
    } result_t;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic [4:0] prescale;
    logic [4:0] bit_cnt;
    logic [4:0] edge_cnt;
    logic       strt_glitch;
    logic       par_err;
    logic       stp_err;
    logic       cnt_enable;
    logic       dat_samp_en;
    logic       strt_chk_en;
    logic       par_chk_en;
    logic       stp_chk_en;
    logic       deser_en;
    logic       data_valid;
    logic       par_error;
    logic       stop_error;
    logic       busy;

    result_t expq[$];
    result_t acc;
    int      compared   = 0;
    int      mismatched = 0;
    int      evIdx      = 0;
    bit      prevBusy   = 1'b0;
    bit      prevDone   = 1'b0;

    uart_rx_fsm #(.DATA_WIDTH(DW)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .PAR_EN      (PAR_EN),
        .prescale    (prescale),
        .bit_cnt     (bit_cnt),
        .edge_cnt    (edge_cnt),
        .strt_glitch (strt_glitch),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .cnt_enable  (cnt_enable),
        .dat_samp_en (dat_samp_en),
        .strt_chk_en (strt_chk_en),
        .par_chk_en  (par_chk_en),
        .stp_chk_en  (stp_chk_en),
        .deser_en    (deser_en),
        .data_valid  (data_valid),
        .par_error   (par_error),
        .stop_error  (stop_error),
        .busy        (busy)
    );

    always #5 CLK = ~CLK;

    function automatic logic [9:0] outVec();
        return {cnt_enable, dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en,
                deser_en, data_valid, par_error, stop_error, busy};
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Outcome of one frame attempt, derived from the frame parameters alone.
    function automatic result_t modelFrame(input int psc, input bit parEn, input bit glitch,
                                           input bit perr, input bit serr, input int abortKind);
        result_t r;
        r = '{default: 0};
        r.strt = 1;
        if (glitch) begin
            r.cntCyc = psc;
        end else if (abortKind != 0) begin
            r.deser  = ABORT_BIT - 1;
            r.cntCyc = psc * ABORT_BIT + ABORT_EDGE + 1;
        end else begin
            r.completed = 1'b1;
            r.deser     = DW;
            r.parc      = int'(parEn);
            r.stpc      = 1;
            r.pe        = parEn & perr;
            r.se        = serr;
            r.dv        = !(r.pe || r.se);
            r.cntCyc    = psc * (DW + 2 + int'(parEn));
        end
        r.sampCyc = r.cntCyc;
        return r;
    endfunction

    task automatic finishEvent();
        result_t exp;
        string   tag;
        acc.dv = data_valid;
        acc.pe = par_error;
        acc.se = stop_error;
        tag    = $sformatf("frame%0d", evIdx);
        if (expq.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s_unexpected_event: got an end-of-frame event, expected none", tag);
        end else begin
            exp = expq.pop_front();
            checkOutput({tag, "_completed"}, int'(acc.completed), int'(exp.completed));
            checkOutput({tag, "_data_valid"}, int'(acc.dv), int'(exp.dv));
            checkOutput({tag, "_par_error"}, int'(acc.pe), int'(exp.pe));
            checkOutput({tag, "_stop_error"}, int'(acc.se), int'(exp.se));
            checkOutput({tag, "_strt_chk_cnt"}, acc.strt, exp.strt);
            checkOutput({tag, "_deser_cnt"}, acc.deser, exp.deser);
            checkOutput({tag, "_par_chk_cnt"}, acc.parc, exp.parc);
            checkOutput({tag, "_stp_chk_cnt"}, acc.stpc, exp.stpc);
            checkOutput({tag, "_strobe_off_chk"}, acc.offchk, exp.offchk);
            checkOutput({tag, "_dv_outside_done"}, acc.dvout, exp.dvout);
            checkOutput({tag, "_cnt_enable_cycles"}, acc.cntCyc, exp.cntCyc);
            checkOutput({tag, "_samp_en_cycles"}, acc.sampCyc, exp.sampCyc);
        end
        acc = '{default: 0};
        evIdx++;
    endtask

    // Monitor: accumulates strobes per frame and closes a frame on DONE or on a drop to idle.
    always @(negedge CLK) begin : monitor
        bit isDone;
        bit strobe;
        isDone = busy && !cnt_enable;
        strobe = strt_chk_en | deser_en | par_chk_en | stp_chk_en;
        if (strt_chk_en) acc.strt++;
        if (deser_en) acc.deser++;
        if (par_chk_en) acc.parc++;
        if (stp_chk_en) acc.stpc++;
        if (strobe && int'(edge_cnt) != int'(prescale) / 2 + 2) acc.offchk++;
        if (data_valid && !isDone) acc.dvout++;
        if (cnt_enable) acc.cntCyc++;
        if (dat_samp_en) acc.sampCyc++;
        if (busy && cnt_enable && (!prevBusy || prevDone)) begin
            checkOutput($sformatf("frame%0d_flags_clear_at_start", evIdx),
                        int'({par_error, stop_error}), 0);
        end
        if (isDone) begin
            acc.completed = 1'b1;
            finishEvent();
        end else if (!busy && prevBusy && !prevDone) begin
            acc.completed = 1'b0;
            finishEvent();
        end
        prevBusy = busy;
        prevDone = isDone;
    end

    // One clock of the external edge/bit counter, which runs while cnt_enable is high.
    task automatic step();
        bit en;
        en = cnt_enable;
        @(posedge CLK);
        #1;
        if (!en || RST) begin
            edge_cnt = '0;
            bit_cnt  = '0;
        end else if (edge_cnt == prescale - 5'd1) begin
            edge_cnt = '0;
            bit_cnt  = bit_cnt + 5'd1;
        end else begin
            edge_cnt = edge_cnt + 5'd1;
        end
    endtask

    task automatic idleCycles(input int n);
        RX_IN = 1'b1;
        repeat (n) begin
            step();
            strt_glitch = 1'($urandom_range(1));
            par_err     = 1'($urandom_range(1));
            stp_err     = 1'($urandom_range(1));
        end
    endtask

    task automatic driveFrameInputs(input int psc, input bit parEn, input bit glitch,
                                    input bit perr, input bit serr, input logic [DW-1:0] data);
        int b;
        int e;
        int stopIdx;
        bit bitEnd;
        b       = int'(bit_cnt);
        e       = int'(edge_cnt);
        stopIdx = DW + 1 + int'(parEn);
        bitEnd  = (e == psc - 1);
        if (b == 0) RX_IN = (glitch && e >= 2) ? 1'b1 : 1'b0;
        else if (b <= DW) RX_IN = data[b-1];
        else if (parEn && b == DW + 1) RX_IN = (^data) ^ perr;
        else if (b == stopIdx) RX_IN = !serr;
        else RX_IN = 1'b1;
        strt_glitch = (b == 0 && bitEnd) ? glitch : 1'($urandom_range(1));
        par_err     = (parEn && b == DW + 1 && bitEnd) ? perr : 1'($urandom_range(1));
        stp_err     = (b == stopIdx && bitEnd) ? serr : 1'($urandom_range(1));
    endtask

    // abortKind: 0 = none, 1 = reset during data bit 4, 2 = prescale changed to 12 there.
    task automatic applyStimulus(input int psc, input bit parEn, input bit glitch, input bit perr,
                                 input bit serr, input int abortKind, input logic [DW-1:0] data);
        int cycles;
        bit aborted;
        expq.push_back(modelFrame(psc, parEn, glitch, perr, serr, abortKind));
        prescale = 5'(psc);
        PAR_EN   = parEn;
        RX_IN    = 1'b0;
        cycles   = 0;
        aborted  = 1'b0;
        do begin
            step();
            RST = 1'b0;
            cycles++;
            driveFrameInputs(psc, parEn, glitch, perr, serr, data);
            if (abortKind != 0 && !aborted && int'(bit_cnt) == ABORT_BIT &&
                int'(edge_cnt) == ABORT_EDGE) begin
                aborted = 1'b1;
                if (abortKind == 1) RST = 1'b1;
                else prescale = 5'd12;
            end
        end while (cycles < FRAME_BUDGET && busy && cnt_enable);
        checkOutput("frame_timeout", int'(cycles >= FRAME_BUDGET), 0);
        if (cycles >= FRAME_BUDGET) begin
            RST = 1'b1;
            step();
            RST = 1'b0;
        end
        RX_IN = 1'b1;
    endtask

    initial begin
        RST         = 1'b1;
        RX_IN       = 1'b0;
        PAR_EN      = 1'b0;
        prescale    = 5'd8;
        bit_cnt     = '0;
        edge_cnt    = '0;
        strt_glitch = 1'b0;
        par_err     = 1'b0;
        stp_err     = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checkOutput("reset_outputs", int'(outVec()), 0);
        RX_IN = 1'b1;
        RST   = 1'b0;
        idleCycles(2);
        @(negedge CLK);
        checkOutput("idle_after_reset", int'(outVec()), 0);

        applyStimulus(8, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'h55);
        idleCycles(3);

        applyStimulus(16, 1'b1, 1'b0, 1'b1, 1'b0, 0, 8'hA3);
        idleCycles(3);
        @(negedge CLK);
        checkOutput("par_error_held", int'(par_error), 1);
        checkOutput("stop_error_held", int'(stop_error), 0);
        checkOutput("no_dv_after_bad_frame", int'(data_valid), 0);

        applyStimulus(8, 1'b0, 1'b1, 1'b0, 1'b0, 0, 8'hFF);
        idleCycles(2);
        @(negedge CLK);
        checkOutput("idle_after_glitch", int'(busy), 0);

        applyStimulus(8, 1'b1, 1'b0, 1'b0, 1'b0, 0, 8'h3C);
        @(negedge CLK);
        checkOutput("b2b_done_cnt_enable", int'(cnt_enable), 0);
        checkOutput("b2b_done_busy", int'(busy), 1);
        applyStimulus(8, 1'b1, 1'b0, 1'b0, 1'b0, 0, 8'hC3);
        idleCycles(3);

        applyStimulus(16, 1'b0, 1'b0, 1'b0, 1'b0, 1, 8'h5A);
        @(negedge CLK);
        checkOutput("outputs_after_midframe_reset", int'(outVec()), 0);
        applyStimulus(16, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'h96);
        idleCycles(3);

        applyStimulus(16, 1'b1, 1'b0, 1'b0, 1'b0, 2, 8'h0F);
        RX_IN = 1'b0;
        repeat (3) step();
        @(negedge CLK);
        checkOutput("illegal_prescale_busy", int'(busy), 0);
        checkOutput("illegal_prescale_cnt_enable", int'(cnt_enable), 0);
        prescale = 5'd16;
        idleCycles(2);

        for (int i = 0; i < NUM_RANDOM; i++) begin
            int psc;
            bit pe;
            bit gl;
            bit perr;
            bit serr;
            psc  = ($urandom_range(1) == 1) ? 16 : 8;
            pe   = 1'($urandom_range(1));
            gl   = ($urandom_range(5) == 0);
            perr = 1'($urandom_range(1));
            serr = ($urandom_range(3) == 0);
            applyStimulus(psc, pe, gl, perr, serr, 0, 8'($urandom));
            if ($urandom_range(1) == 0) idleCycles($urandom_range(4, 1));
        end
        idleCycles(5);
        checkOutput("scoreboard_drained", expq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
